// File: rtl/apb_master_mux.sv
// apb_master_mux: APB4 master decoding NUM_SLAVES windows from address bits, one outstanding transfer.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_mux #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  output logic [2:0]                       pprot,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);
  localparam int IDX_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_mux: unsupported parameter values");
  end
  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      cmd_idx;
  logic                  dec_ok;
  logic                  sel_rdy;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  expired;
  assign cmd_idx   = cmd_addr[SLAVE_ADDR_BITS +: IDX_W];
  assign dec_ok    = 32'(cmd_idx) < NUM_SLAVES;
  assign sel_rdy   = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign cmd_ready = state_q == IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  assign expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  // Held at zero outside ACCESS, so it is already clear on entry.
  always_ff @(posedge clk)
    if (rst || state_q != ACCESS) cnt_q <= '0;
    else if (!sel_rdy) cnt_q <= cnt_q + 1'b1;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          idx_q     <= cmd_idx;
          pwrite    <= cmd_write;
          paddr     <= cmd_addr;
          pwdata    <= cmd_wdata;
          pstrb     <= cmd_write ? cmd_strb : '0;
          pprot     <= cmd_prot;
          psel      <= dec_ok ? NUM_SLAVES'(1) << cmd_idx : '0;
          rsp_valid <= !dec_ok;
          rsp_err   <= !dec_ok;
          rsp_rdata <= '0;
          state_q   <= dec_ok ? SETUP : RESP;
        end
        SETUP: begin
          penable <= 1'b1;
          state_q <= ACCESS;
        end
        // A ready on the expiry cycle wins over the timeout.
        ACCESS: if (sel_rdy || expired) begin
          psel      <= '0;
          penable   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= !sel_rdy || sel_err;
          rsp_rdata <= (sel_rdy && !sel_err && !pwrite) ? sel_rdata : '0;
          state_q   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised APB4 master for the APB-AXI4-lite bridge.
- Accepts single transfer commands from the bridge core on a valid/ready command channel.
- Decodes the target among NUM_SLAVES APB slaves from address bits and runs the SETUP/ACCESS protocol with wait states.
- Returns read data and error status on a valid/ready response channel.
- Generalises the single-select APB master: multi-slave decode, response backpressure, decode errors and an optional timeout.

Parameters:
- DATA_WIDTH, 32, APB data width; 8, 16 or 32.
- ADDR_WIDTH, 32, APB address width.
- NUM_SLAVES, 4, number of APB slaves; 1..16.
- SLAVE_ADDR_BITS, 12, address bits per slave window; slave index = addr[SLAVE_ADDR_BITS +: IDX_W], where IDX_W = max(1, clog2(NUM_SLAVES)).
- TIMEOUT_CYCLES, 256, number of ACCESS cycles before abort; used only with APB_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR, decode error or timeout
- psel  out  NUM_SLAVES  one-hot slave select
- penable  out  1  APB enable
- pwrite  out  1  APB write
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- pprot  out  3  APB protection
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset: single clock clk; reset rst is synchronous and active-high.
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata and rsp_err reset to 0.
  - cmd_ready is 1 in the first cycle after reset.
- Reset mid-transfer: rst asserted in any state returns the block to IDLE on the next edge. Any in-flight transfer and pending response are dropped; no response is issued.
- State IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register all cmd_* fields into the APB output registers.
  - If the index is < NUM_SLAVES, go to SETUP.
  - Otherwise (decode error), go to RESP with rsp_err = 1 and rsp_rdata = 0; no psel is asserted.
- State SETUP (exactly 1 cycle):
  - psel[idx] = 1, penable = 0, all other psel bits 0.
  - Go to ACCESS.
- State ACCESS:
  - psel[idx] = 1, penable = 1.
  - Address, control and data are held stable.
  - While pready[idx] = 0, stay in ACCESS (wait state).
  - When pready[idx] = 1: capture rsp_err = pslverr[idx]. Capture rsp_rdata = prdata slice for reads without error, else 0. Go to RESP.
  - Deassert psel and penable on the same edge.
- State RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held until rsp_ready.
  - On rsp_ready, go to IDLE.
  - cmd_ready = 0 in SETUP, ACCESS and RESP; one outstanding transfer only.
- Latency (no wait states, rsp_ready held high):
  - cmd handshake at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3, IDLE at cycle 4.
  - Minimum 4 cycles between accepted commands.
- pstrb: driven as cmd_strb for writes and forced to 0 for reads (APB4 rule).
- Out-of-window slaves: pready and pslverr of unselected slaves are ignored.
- NUM_SLAVES = 1: IDX_W = 1; index 1 is a decode error.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready[idx] = 0.
  - When the count reaches TIMEOUT_CYCLES-1 without pready, the next edge deasserts psel and penable and goes to RESP with rsp_err = 1 and rsp_rdata = 0.
  - pready arriving on the expiry cycle takes priority and completes normally.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Read, slave 2, zero wait:
  - Stimulus: cmd_addr = 0x2010, prdata slice 2 = 0xDEADBEEF.
  - Response: psel = 4'b0100 for 2 cycles, penable high in cycle 2 only, rsp_valid in cycle 3 with rdata 0xDEADBEEF and err 0.
- Write, slave 1, 3 wait states:
  - Stimulus: addr 0x1004, wdata 0x12345678, strb 4'b0011.
  - Response: ACCESS lasts 4 cycles with paddr, pwdata and pstrb stable; rsp_valid with rdata 0 and err 0.
- PSLVERR on a read from slave 0:
  - Response: rsp_err = 1 and rsp_rdata = 0.
- Decode error:
  - Stimulus: NUM_SLAVES = 3, addr 0x3000.
  - Response: psel stays 0, rsp_valid one cycle after accept with err = 1.
- Response backpressure and reset:
  - Stimulus: hold rsp_ready = 0 for 5 cycles.
  - Response: rsp fields stable and cmd_ready = 0 throughout.
  - Stimulus: assert rst during ACCESS.
  - Response: all outputs 0 and cmd_ready = 1 the next cycle.
- Timeout (APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, pready stuck at 0):
  - Response: abort after 8 ACCESS cycles with err = 1.
  - Macro undefined: still in ACCESS after 1000 cycles.
